// File: rtl/capture_reader.sv
// Read-out engine for the sampler's circular capture buffer: streams samples oldest-first over valid/ready.
// Optional build macro CAPTURE_READER_DECIMATE_EN adds a decim port that strides the read-out by 2^decim.
module capture_reader #(
    parameter int SAMPLE_DEPTH = 8
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    start,
    output logic                    done,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    output logic                    mem_re,
    input  logic [7:0]              mem_data,
    output logic [7:0]              out_data,
    output logic [SAMPLE_DEPTH-1:0] out_index,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef CAPTURE_READER_DECIMATE_EN
    input  logic [1:0]              decim,
`endif
    output logic                    out_last
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [SAMPLE_DEPTH-1:0] HALF_SPAN  = SAMPLE_DEPTH'(1) << (SAMPLE_DEPTH - 1);
    localparam logic [SAMPLE_DEPTH:0]   FULL_COUNT = (SAMPLE_DEPTH + 1)'(1) << SAMPLE_DEPTH;

    logic [2:0]              state;
    // One bit wider than the address so the final-index compare cannot alias at wrap.
    logic [SAMPLE_DEPTH:0]   idx;
    logic [SAMPLE_DEPTH-1:0] step;
    logic [SAMPLE_DEPTH:0]   last_idx;

`ifdef CAPTURE_READER_DECIMATE_EN
    logic [1:0] decim_q;

    assign step     = SAMPLE_DEPTH'(1) << decim_q;
    assign last_idx = (FULL_COUNT >> decim_q) - (SAMPLE_DEPTH + 1)'(1);
`else
    assign step     = SAMPLE_DEPTH'(1);
    assign last_idx = FULL_COUNT - (SAMPLE_DEPTH + 1)'(1);
`endif

    assign out_index = idx[SAMPLE_DEPTH-1:0];

    // NOTE: every register below uses <= so all updates in a cycle see pre-edge values.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef CAPTURE_READER_DECIMATE_EN
            decim_q   <= '0;
`endif
        end else begin
            mem_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr <= offset + HALF_SPAN;
                        mem_re   <= 1'b1;
                        idx      <= '0;
`ifdef CAPTURE_READER_DECIMATE_EN
                        decim_q  <= decim;
`endif
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    out_data  <= mem_data;
                    out_valid <= 1'b1;
                    out_last  <= (idx == last_idx);
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_addr <= mem_addr + step;
                            mem_re   <= 1'b1;
                            idx      <= idx + (SAMPLE_DEPTH + 1)'(1);
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    // Only a low start re-arms the engine, so a held start cannot retrigger.
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_reader.sv
// Self-checking bench for capture_reader: vector table of read-outs plus randomized runs against an address model.
module tb_capture_reader;

    localparam int SD = 8;
    localparam int N  = 1 << SD;

    logic          clk_50mhz = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [SD-1:0] offset;
    logic [SD-1:0] mem_addr;
    logic          mem_re;
    logic [7:0]    mem_data;
    logic [7:0]    out_data;
    logic [SD-1:0] out_index;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
`ifdef CAPTURE_READER_DECIMATE_EN
    logic [1:0]    decim;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem      [N];
    logic [7:0] got_data [N];
    int         got_count;
    int         cycles_to_done;
    int         first_valid_cycle;

    typedef struct {
        logic [7:0] off;
        int         mode;       // 0: ready high, 1: random ready, 2: 5-cycle stall on index 3
        logic [7:0] first;
        logic [7:0] at_90;
        logic [7:0] last;
    } vec_t;

    vec_t vecs [4];

    capture_reader #(.SAMPLE_DEPTH(SD)) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .offset    (offset),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CAPTURE_READER_DECIMATE_EN
        .decim     (decim),
`endif
        .out_last  (out_last)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk_50mhz) begin
        if (mem_re) mem_data <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Address of chronological sample k: oldest sample sits half a buffer after the trigger.
    function automatic logic [SD-1:0] model_addr(input logic [SD-1:0] off, input int step, input int k);
        return SD'((int'(off) + N / 2 + k * step) % N);
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, {done, out_valid, out_last, mem_re, mem_addr, out_data, out_index}, 32'h0);
    endtask

    task automatic run_readout(input logic [SD-1:0] off, input int step, input int mode,
                               input int special_idx, input bit abort);
        int         len         = N / step;
        int         k           = 0;
        int         c           = 0;
        int         stall       = 0;
        int         last_accept = -10;
        bit         prev_accept = 1'b0;
        bit         finished    = 1'b0;
        logic [7:0] snap_data   = '0;
        logic [SD-1:0] snap_idx = '0;
        got_count         = 0;
        cycles_to_done    = -1;
        first_valid_cycle = -1;
        @(negedge clk_50mhz);
        offset    = off;
        start     = 1'b1;
        out_ready = 1'b0;
        while (!finished && c < 8 * N) begin
            @(negedge clk_50mhz);
            c++;
            offset = SD'($urandom);   // must be ignored after the start edge
            if (mem_re) check("read_addr", mem_addr, model_addr(off, step, k));
            if (prev_accept) check("valid_drop", out_valid, 1'b0);
            prev_accept = 1'b0;
            if (out_valid) begin
                if (first_valid_cycle < 0) first_valid_cycle = c;
                if (abort && int'(out_index) == special_idx) begin
                    reset     = 1'b1;
                    start     = 1'b0;
                    out_ready = 1'b0;
                    finished  = 1'b1;
                end else begin
                    case (mode)
                        0: out_ready = 1'b1;
                        1: out_ready = ($urandom_range(0, 2) != 0);
                        default: begin
                            if (int'(out_index) == special_idx && stall < 5) begin
                                if (stall == 0) begin
                                    snap_data = out_data;
                                    snap_idx  = out_index;
                                end else begin
                                    check("stall_data", out_data, snap_data);
                                    check("stall_index", out_index, snap_idx);
                                end
                                check("stall_no_read", mem_re, 1'b0);
                                stall++;
                                out_ready = 1'b0;
                            end else begin
                                out_ready = 1'b1;
                            end
                        end
                    endcase
                    if (out_ready) begin
                        check("sample", {out_data, out_index, out_last},
                              {mem[model_addr(off, step, k)], SD'(k), (k == len - 1)});
                        got_data[k] = out_data;
                        k++;
                        got_count   = k;
                        prev_accept = 1'b1;
                        last_accept = c;
                    end
                end
            end else begin
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (!finished && done) begin
                cycles_to_done = c;
                check("done_count", k, len);
                check("done_latency", c, last_accept + 1);
                finished = 1'b1;
            end
        end
        check("readout_finished", finished, 1'b1);
    endtask

    task automatic hold_then_release();
        int stray_reads = 0;
        int done_lows   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50mhz);
            if (mem_re) stray_reads++;
            if (!done) done_lows++;
        end
        check("held_start_no_reads", stray_reads, 0);
        check("held_start_done", done_lows, 0);
        start = 1'b0;
        @(negedge clk_50mhz);
        check("done_fall", done, 1'b0);
    endtask

    initial begin
        vecs[0] = '{off: 8'h10, mode: 0, first: 8'h90, at_90: 8'h20, last: 8'h8F};
        vecs[1] = '{off: 8'hF0, mode: 0, first: 8'h70, at_90: 8'h00, last: 8'h6F};
        vecs[2] = '{off: 8'h80, mode: 1, first: 8'h00, at_90: 8'h90, last: 8'hFF};
        vecs[3] = '{off: 8'h7F, mode: 2, first: 8'hFF, at_90: 8'h8F, last: 8'hFE};

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        offset    = '0;
`ifdef CAPTURE_READER_DECIMATE_EN
        decim     = 2'd0;
`endif
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        repeat (2) @(negedge clk_50mhz);
        check_reset_outputs("reset_values");
        reset = 1'b0;
        @(negedge clk_50mhz);

        for (int v = 0; v < 4; v++) begin
            run_readout(vecs[v].off, 1, vecs[v].mode, 3, 1'b0);
            check("first_sample", got_data[0], vecs[v].first);
            check("sample_0x90", got_data[8'h90], vecs[v].at_90);
            check("last_sample", got_data[N - 1], vecs[v].last);
            if (vecs[v].mode == 0) begin
                check("first_valid_latency", first_valid_cycle, 3);
                check("readout_cycles", cycles_to_done, 3 * N + 1);
            end
            hold_then_release();
        end

        // Random memory contents and offsets with random backpressure.
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < N; a++) mem[a] = 8'($urandom);
            run_readout(SD'($urandom), 1, 1, 0, 1'b0);
            hold_then_release();
        end

        // Reset in the middle of a read-out, then a complete read-out afterwards.
        run_readout(8'h33, 1, 1, 40, 1'b1);
        @(negedge clk_50mhz);
        check_reset_outputs("mid_reset_values");
        reset = 1'b0;
        begin
            int activity = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_50mhz);
                if (mem_re || out_valid || done) activity++;
            end
            check("idle_after_reset", activity, 0);
        end
        run_readout(8'hC5, 1, 1, 0, 1'b0);
        check("post_reset_count", got_count, N);
        hold_then_release();

`ifdef CAPTURE_READER_DECIMATE_EN
        for (int a = 0; a < N; a++) mem[a] = 8'(a);
        decim = 2'd2;
        run_readout(8'h10, 4, 0, 0, 1'b0);
        check("decim_count", got_count, N / 4);
        check("decim_first", got_data[0], 8'h90);
        check("decim_second", got_data[1], 8'h94);
        check("decim_last", got_data[N / 4 - 1], 8'h8C);
        hold_then_release();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
